// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: frame-granular round-robin arbiter feeding the udp_tx_full
// byte interface. Enforces an inter-frame gap after every forwarded last byte.
// Optional stall timeout: define UDP_ARB_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | no owner, searching for a first byte from the pointer onwards
//   PASS   | owner granted, bytes forwarded one per accept
//   GAP    | inter-frame gap countdown, nothing accepted
module udp_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IFG     = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 wr_clk_i,
    input  logic                 rst_n_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ-1:0]   req_first_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_in_o,
    output logic                 tx_in_valid_o,
    output logic                 tx_in_first_o,
    output logic                 tx_in_last_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic [15:0]          frame_cnt_o,
    output logic                 err_timeout_o
);

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || IFG < 1 || IFG > 255 ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_err
        $error("udp_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                tx_first_q, tx_first_d;
    logic                tx_last_q, tx_last_d;
    logic                first_pend_q, first_pend_d;
    logic                busy_q, busy_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [7:0]          gap_q, gap_d;
`ifdef UDP_ARB_TIMEOUT_EN
    logic [7:0]          stall_q, stall_d;
    logic                err_q, err_d;
`endif

    logic [2*NUM_REQ-1:0] elig2;
    logic                 found;
    logic [PW-1:0]        win;
    logic                 accept;
    logic [7:0]           sel_data;
    logic                 sel_last;

    // eligibility vector doubled so the pointer-relative search needs no wrap logic
    assign elig2    = {req_valid_i & req_first_i, req_valid_i & req_first_i};
    assign accept   = (state_q == S_PASS) && req_valid_i[owner_q];
    assign sel_data = req_data_i[{owner_q, 3'b000} +: 8];
    assign sel_last = req_last_i[owner_q];

    // only the owner sees ready, and only while passing
    always_comb begin
        req_ready_o = (state_q == S_PASS) ? grant_q : '0;
    end

    // next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        tx_first_d   = 1'b0;
        tx_last_d    = 1'b0;
        first_pend_d = first_pend_q;
        frame_cnt_d  = frame_cnt_q;
        gap_d        = gap_q;
        found        = 1'b0;
        win          = '0;
`ifdef UDP_ARB_TIMEOUT_EN
        stall_d      = stall_q;
        err_d        = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!found && elig2[int'(ptr_q) + k]) begin
                        found = 1'b1;
                        win   = PW'((int'(ptr_q) + k) % NUM_REQ);
                    end
                end
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    owner_d      = win;
                    ptr_d        = (int'(win) == NUM_REQ - 1) ? '0 : win + PW'(1);
                    first_pend_d = 1'b1;
                    state_d      = S_PASS;
`ifdef UDP_ARB_TIMEOUT_EN
                    stall_d      = '0;
`endif
                end
            end
            S_PASS: begin
                if (accept) begin
                    tx_data_d    = sel_data;
                    tx_valid_d   = 1'b1;
                    tx_first_d   = first_pend_q;
                    tx_last_d    = sel_last;
                    first_pend_d = 1'b0;
`ifdef UDP_ARB_TIMEOUT_EN
                    stall_d      = '0;
`endif
                    if (sel_last) begin
                        grant_d     = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        gap_d       = 8'(IFG);
                        state_d     = S_GAP;
                    end
                end
`ifdef UDP_ARB_TIMEOUT_EN
                else if (stall_q == 8'(TIMEOUT - 1)) begin
                    // abandon the frame: close it downstream with a dummy last byte
                    tx_data_d   = 8'h00;
                    tx_valid_d  = 1'b1;
                    tx_last_d   = 1'b1;
                    err_d       = 1'b1;
                    grant_d     = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_d       = 8'(IFG);
                    state_d     = S_GAP;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
`endif
            end
            S_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // state and output registers, synchronous active-low reset
    always_ff @(posedge wr_clk_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            grant_q      <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            tx_first_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            first_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= 16'd0;
            gap_q        <= 8'd0;
`ifdef UDP_ARB_TIMEOUT_EN
            stall_q      <= 8'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_first_q   <= tx_first_d;
            tx_last_q    <= tx_last_d;
            first_pend_q <= first_pend_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
            gap_q        <= gap_d;
`ifdef UDP_ARB_TIMEOUT_EN
            stall_q      <= stall_d;
            err_q        <= err_d;
`endif
        end
    end

    assign tx_in_o       = tx_data_q;
    assign tx_in_valid_o = tx_valid_q;
    assign tx_in_first_o = tx_first_q;
    assign tx_in_last_o  = tx_last_q;
    assign grant_o       = grant_q;
    assign busy_o        = busy_q;
    assign frame_cnt_o   = frame_cnt_q;
`ifdef UDP_ARB_TIMEOUT_EN
    assign err_timeout_o = err_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule
